uart_tx: RTL and testbench

Serial transmitter that turns the byte-wide `transmit`/`tx_byte` requests issued by the host-link memory controller into an asynchronous 8N1 (optionally 8E1/8O1) frame on a single TX pin. It sits directly downstream of the controller. It reports `is_transmitting` back so the controller can pace memory reads one byte per frame. The block contains a baud divider, a frame shifter and a small state machine.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_baud_gen.sv | 30 +++
 rtl/uart_tx.sv | 122 ++++++++++++
 tb/tb_uart_tx.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, data width and baud-divisor derivation.
// Intended to be imported by both uart_tx and a future uart_rx.
package uart_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  // Integer divisor; no fractional correction is applied anywhere downstream.
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

  function automatic logic parity_of(input logic [DATA_W-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period divider: counts 0..CLKS_PER_BIT-1 and pulses tick on the last count.
// Holding clr keeps the count at zero so the first bit after release is full length.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  // Bit-period counter, wraps at each bit boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick = !clr && (cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// Byte-to-serial UART transmitter (8N1 by default) with registered tx and is_transmitting.
// Define UART_TX_PARITY_EN to insert a parity bit (8E1/8O1 selected by PARITY_ODD).
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 12000000,
  parameter int BAUD       = 9600,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              transmit,
  input  logic [DATA_W-1:0] tx_byte,
  output logic              is_transmitting,
  output logic              tx
);

  localparam int         CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
  localparam logic       LAST_STOP    = (STOP_BITS >= 2) ? 1'b1 : 1'b0;
  localparam logic [2:0] LAST_BIT     = 3'(DATA_W - 1);

  uart_state_e       state;
  logic [DATA_W-1:0] shreg;
  logic [2:0]        bit_idx;
  logic              stop_idx;
  logic              tick;
  logic              baud_clr;
`ifdef UART_TX_PARITY_EN
  logic              par;
`endif

  // Values other than 0/1 for the parity sense have no defined meaning.
  if (PARITY_ODD > 1) begin : g_parity_odd_out_of_range
  end

  assign baud_clr = (state == IDLE);

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (baud_clr),
    .tick (tick)
  );

  // Frame FSM; outputs are registered from the current state, so they trail it by one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      shreg           <= '0;
      bit_idx         <= 3'd0;
      stop_idx        <= 1'b0;
      tx              <= 1'b1;
      is_transmitting <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par             <= 1'b0;
`endif
    end else begin
      is_transmitting <= (state != IDLE);
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (transmit) begin
            shreg    <= tx_byte;
            bit_idx  <= 3'd0;
            stop_idx <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par      <= parity_of(tx_byte, (PARITY_ODD != 0));
`endif
            state    <= START;
          end
        end
        START: begin
          tx <= 1'b0;
          if (tick) begin
            state <= DATA;
          end
        end
        DATA: begin
          tx <= shreg[0];
          if (tick) begin
            shreg <= shreg >> 1;
            if (bit_idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          tx <= par;
          if (tick) begin
            state <= STOP;
          end
        end
`endif
        STOP: begin
          tx <= 1'b1;
          if (tick) begin
            if (stop_idx == LAST_STOP) begin
              state <= IDLE;
            end else begin
              stop_idx <= 1'b1;
            end
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: lane 0 uses one stop bit, lane 1 two stop bits (CLKS_PER_BIT = 4).
module tb_uart_tx;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef struct {
    logic [11:0] bits;
    int          nbits;
    int          flen;
    bit          abort;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst0_n, rst1_n, tr0, tr1;
  logic [7:0] byte0, byte1;
  logic       tx0, tx1, busy0, busy1;

  exp_t q0[$];
  exp_t q1[$];
  int   frames[2];
  int   n_pass = 0;
  int   n_total = 0;

  uart_tx #(.CLK_HZ(40), .BAUD(10), .STOP_BITS(1), .PARITY_ODD(0)) dut0 (
    .clk(clk), .rst_n(rst0_n), .transmit(tr0), .tx_byte(byte0),
    .is_transmitting(busy0), .tx(tx0)
  );

  uart_tx #(.CLK_HZ(40), .BAUD(10), .STOP_BITS(2), .PARITY_ODD(0)) dut1 (
    .clk(clk), .rst_n(rst1_n), .transmit(tr1), .tx_byte(byte1),
    .is_transmitting(busy1), .tx(tx1)
  );

  always #5 clk = ~clk;

  function automatic logic tx_of(input int lane);
    return (lane != 0) ? tx1 : tx0;
  endfunction

  function automatic logic busy_of(input int lane);
    return (lane != 0) ? busy1 : busy0;
  endfunction

  function automatic logic rst_of(input int lane);
    return (lane != 0) ? rst1_n : rst0_n;
  endfunction

  function automatic int qsize(input int lane);
    return (lane != 0) ? q1.size() : q0.size();
  endfunction

  function automatic exp_t pop_exp(input int lane);
    if (lane != 0) return q1.pop_front();
    return q0.pop_front();
  endfunction

  // Expected line bits: start, data LSB first, optional parity, stop bits.
  function automatic exp_t mk(input logic [7:0] b, input int stop, input logic par);
    exp_t e;
    int   n;
    e.bits    = '0;
    e.bits[0] = 1'b0;
    n = 1;
    for (int i = 0; i < 8; i++) begin
      e.bits[n] = b[i];
      n++;
    end
    if (PAR_EN) begin
      e.bits[n] = par;
      n++;
    end
    for (int s = 0; s < stop; s++) begin
      e.bits[n] = 1'b1;
      n++;
    end
    e.nbits = n;
    e.flen  = n * CPB;
    e.abort = 1'b0;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic send(input int lane, input logic [7:0] b, input logic par,
                      input bit accept, input bit abort);
    exp_t e;
    if (accept) begin
      e = mk(b, (lane != 0) ? 2 : 1, par);
      e.abort = abort;
      if (lane != 0) q1.push_back(e);
      else q0.push_back(e);
    end
    if (lane != 0) begin tr1 = 1'b1; byte1 = b; end
    else begin tr0 = 1'b1; byte0 = b; end
    @(negedge clk);
    if (lane != 0) begin tr1 = 1'b0; byte1 = ~b; end
    else begin tr0 = 1'b0; byte0 = ~b; end
  endtask

  task automatic wait_level(input int lane, input logic lvl, input int budget, input string name);
    int i = 0;
    while (busy_of(lane) !== lvl && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk(name, 32'(busy_of(lane)), 32'(lvl));
  endtask

  task automatic wait_frame(input int lane, input string name);
    wait_level(lane, 1'b1, 10, name);
    wait_level(lane, 1'b0, 100, name);
  endtask

  task automatic monitor(input int lane);
    exp_t        e;
    logic [11:0] got;
    int          hi;
    int          guard;
    forever begin
      @(negedge clk);
      if (rst_of(lane) === 1'b1 && tx_of(lane) === 1'b0) begin
        if (qsize(lane) == 0) begin
          chk("unexpected_start", 32'(tx_of(lane)), 32'd1);
          guard = 0;
          while (tx_of(lane) !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
          end
        end else begin
          e = pop_exp(lane);
          if (e.abort) begin
            guard = 0;
            while (rst_of(lane) !== 1'b0 && guard < 200) begin
              @(negedge clk);
              guard++;
            end
            guard = 0;
            while (rst_of(lane) !== 1'b1 && guard < 200) begin
              @(negedge clk);
              guard++;
            end
          end else begin
            got = '0;
            hi  = 0;
            for (int b = 0; b < e.nbits; b++) begin
              for (int c = 0; c < CPB; c++) begin
                if (b != 0 || c != 0) @(negedge clk);
                if (c == 0) got[b] = tx_of(lane);
                else if (tx_of(lane) !== got[b]) got[b] = 1'bx;
                if (busy_of(lane) === 1'b1) hi++;
              end
            end
            chk((lane != 0) ? "frame_bits_l1" : "frame_bits_l0", 32'(got), 32'(e.bits));
            chk((lane != 0) ? "busy_cycles_l1" : "busy_cycles_l0", hi, e.flen);
            @(negedge clk);
            chk((lane != 0) ? "busy_fall_l1" : "busy_fall_l0", 32'(busy_of(lane)), 32'd0);
            frames[lane]++;
          end
        end
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion, expected finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int lows;
    frames[0] = 0;
    frames[1] = 0;
    rst0_n = 1'b0; rst1_n = 1'b0;
    tr0 = 1'b0; tr1 = 1'b0;
    byte0 = 8'h00; byte1 = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_tx_l0", 32'(tx0), 32'd1);
    chk("rst_busy_l0", 32'(busy0), 32'd0);
    chk("rst_tx_l1", 32'(tx1), 32'd1);
    chk("rst_busy_l1", 32'(busy1), 32'd0);
    rst0_n = 1'b1; rst1_n = 1'b1;
    repeat (3) @(negedge clk);

    // Single byte with latency checks around the accepting edge.
    send(0, 8'h55, 1'b0, 1'b1, 1'b0);
    chk("s1_busy_at_k", 32'(busy0), 32'd0);
    @(negedge clk);
    chk("s1_busy_at_k1", 32'(busy0), 32'd1);
    chk("s1_tx_at_k1", 32'(tx0), 32'd0);
    wait_level(0, 1'b0, 100, "s1_done");
    repeat (4) @(negedge clk);

    // Request while busy must be dropped.
    send(0, 8'h00, 1'b0, 1'b1, 1'b0);
    repeat (12) @(negedge clk);
    send(0, 8'hFF, 1'b0, 1'b0, 1'b0);
    wait_level(0, 1'b0, 100, "s2_done");
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx0 !== 1'b1) lows++;
      if (busy0 !== 1'b0) lows++;
    end
    chk("s2_line_idle", lows, 0);

    // Back-to-back: request in the first cycle is_transmitting is low.
    send(0, 8'h3C, 1'b0, 1'b1, 1'b0);
    wait_frame(0, "s3_first");
    send(0, 8'hA3, 1'b0, 1'b1, 1'b0);
    chk("s3_mark_tx", 32'(tx0), 32'd1);
    @(negedge clk);
    chk("s3_start_tx", 32'(tx0), 32'd0);
    chk("s3_start_busy", 32'(busy0), 32'd1);
    wait_level(0, 1'b0, 100, "s3_second");
    repeat (3) @(negedge clk);

    // Reset during data bit 3 of 0x0F, then a clean 0x81 frame.
    send(0, 8'h0F, 1'b0, 1'b1, 1'b1);
    repeat (18) @(negedge clk);
    chk("s4_pre_busy", 32'(busy0), 32'd1);
    rst0_n = 1'b0;
    #1;
    chk("s4_rst_tx", 32'(tx0), 32'd1);
    chk("s4_rst_busy", 32'(busy0), 32'd0);
    repeat (3) @(negedge clk);
    rst0_n = 1'b1;
    repeat (2) @(negedge clk);
    send(0, 8'h81, 1'b0, 1'b1, 1'b0);
    wait_frame(0, "s4_after");

    // Two stop bits on lane 1.
    send(1, 8'hFF, 1'b0, 1'b1, 1'b0);
    wait_frame(1, "s5_done");

`ifdef UART_TX_PARITY_EN
    // Even parity: 0x07 has three ones, 0x03 has two.
    repeat (3) @(negedge clk);
    send(0, 8'h07, 1'b1, 1'b1, 1'b0);
    wait_frame(0, "s6_07");
    repeat (3) @(negedge clk);
    send(0, 8'h03, 1'b0, 1'b1, 1'b0);
    wait_frame(0, "s6_03");
`endif

    repeat (10) @(negedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    chk("frames_l0", frames[0], PAR_EN ? 7 : 5);
    chk("frames_l1", frames[1], 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
